// File: rtl/display_arbiter.sv
// display_arbiter
// Round-robin arbiter that picks one of four requesters and shows its 32-bit
// word on an 8-digit seven-segment display for DWELL clock cycles.
// - The chosen word is captured into a register, so later changes to the
//   source data do not reach the display until the next capture.
// - A one-cycle, one-hot ack pulse marks each capture.
// - 'hold' freezes the dwell count while a word is on show.
module display_arbiter #(
    parameter logic [31:0] DWELL = 32'd50_000_000,
    parameter int          CW    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    input  logic        hold,
    output logic [3:0]  ack,
    output logic [31:0] disp_data,
    output logic [1:0]  disp_src,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Final count of a dwell window; the dwell expires on the edge that sees it.
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 32'd1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_last;
    logic [3:0]    r_ack;
    logic [31:0]   r_dispData;
    logic [1:0]    r_dispSrc;

    state_t        w_nextState;
    logic [CW-1:0] w_nextCnt;
    logic [1:0]    w_nextLast;
    logic [3:0]    w_nextAck;
    logic [31:0]   w_nextData;
    logic [1:0]    w_nextSrc;

    logic          w_found;
    logic [1:0]    w_grantIdx;
    logic [1:0]    w_cand;
    logic [31:0]   w_grantData;
    logic          w_grant;

    // Round-robin search: start just after the last winner and wrap around.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = 2'd0;
        w_cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + k[1:0];
            if (!w_found && req[w_cand]) begin
                w_found    = 1'b1;
                w_grantIdx = w_cand;
            end
        end
    end

    // Select the word of the requester that would win this cycle.
    always_comb begin
        w_grantData = data0;
        case (w_grantIdx)
            2'd0:    w_grantData = data0;
            2'd1:    w_grantData = data1;
            2'd2:    w_grantData = data2;
            default: w_grantData = data3;
        endcase
    end

    // Next-state logic: dwell counting, expiry, and the grant event.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextLast  = r_last;
        w_nextAck   = 4'b0000;
        w_nextData  = r_dispData;
        w_nextSrc   = r_dispSrc;
        w_grant     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant = 1'b1;
                end
            end
            SHOW: begin
                if (!hold) begin
                    if (r_cnt < CNT_LAST) begin
                        w_nextCnt = r_cnt + CW'(1);
                    end else if (w_found) begin
                        w_grant = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                        w_nextCnt   = '0;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase

        if (w_grant) begin
            w_nextState = SHOW;
            w_nextCnt   = '0;
            w_nextLast  = w_grantIdx;
            w_nextAck   = 4'b0001 << w_grantIdx;
            w_nextData  = w_grantData;
            w_nextSrc   = w_grantIdx;
        end
    end

    // State register; reset clears the display and gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last     <= 2'd3;
            r_ack      <= 4'b0000;
            r_dispData <= 32'h0000_0000;
            r_dispSrc  <= 2'd0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_nextCnt;
            r_last     <= w_nextLast;
            r_ack      <= w_nextAck;
            r_dispData <= w_nextData;
            r_dispSrc  <= w_nextSrc;
        end
    end

    assign ack       = r_ack;
    assign disp_data = r_dispData;
    assign disp_src  = r_dispSrc;
    assign busy      = (r_state == SHOW);

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
// Directed scenarios with literal expectations, followed by a randomized run.
// A cycle-level reference model kept here predicts ack/disp_data/disp_src/busy.
module tb_display_arbiter;

    localparam logic [31:0] DWELL = 32'd4;
    localparam int          CW    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] dataArr [4];
    logic        hold;
    logic [3:0]  ack;
    logic [31:0] disp_data;
    logic [1:0]  disp_src;
    logic        busy;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 1'b0;

    // Reference model state: what is on show and how long it has left.
    bit          mBusy;
    int          mRemain;
    int          mLast;
    int          mSrc;
    logic [31:0] mData;
    logic [3:0]  mAck;

    display_arbiter #(.DWELL(DWELL), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (dataArr[0]),
        .data1     (dataArr[1]),
        .data2     (dataArr[2]),
        .data3     (dataArr[3]),
        .hold      (hold),
        .ack       (ack),
        .disp_data (disp_data),
        .disp_src  (disp_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester after lastIdx (wrapping) that is asking, or -1 if none.
    function automatic int pickNext(input logic [3:0] r, input int lastIdx);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (lastIdx + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model: advances once per clock, resets asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy   = 1'b0;
            mRemain = 0;
            mLast   = 3;
            mSrc    = 0;
            mData   = 32'h0;
            mAck    = 4'b0;
        end else begin
            int  g;
            bit  doGrant;
            g       = pickNext(req, mLast);
            doGrant = 1'b0;
            mAck    = 4'b0;
            if (!mBusy) begin
                doGrant = (g >= 0);
            end else if (!hold) begin
                if (mRemain > 0) mRemain = mRemain - 1;
                else if (g >= 0) doGrant = 1'b1;
                else mBusy = 1'b0;
            end
            if (doGrant) begin
                mBusy   = 1'b1;
                mRemain = int'(DWELL) - 1;
                mLast   = g;
                mSrc    = g;
                mData   = dataArr[g];
                mAck    = 4'b0001 << g;
            end
        end
    end

    // Compare every output against the model shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            checkOutput("model_ack",  {28'd0, ack},      {28'd0, mAck});
            checkOutput("model_data", disp_data,         mData);
            checkOutput("model_src",  {30'd0, disp_src}, 32'(mSrc));
            checkOutput("model_busy", {31'd0, busy},     {31'd0, mBusy});
        end
    end

    task automatic applyStimulus(input logic [3:0] reqV, input logic holdV);
        req  = reqV;
        hold = holdV;
    endtask

    task automatic drainToIdle();
        applyStimulus(4'b0000, 1'b0);
        repeat (int'(DWELL) + 1) @(negedge clk);
        checkOutput("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int expSrc;
        logic [3:0] rq;
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) dataArr[i] = 32'h0;
        #2 checkEn = 1'b1;
        #1;
        checkOutput("reset_data", disp_data, 32'h0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("idle_data", disp_data, 32'h0);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("idle_ack",  {28'd0, ack}, 32'd0);
        end

        // All four requesting: strict rotation 0,1,2,3,0 with DWELL spacing
        dataArr[0] = 32'h0000_0000;
        dataArr[1] = 32'h1111_1111;
        dataArr[2] = 32'h2222_2222;
        dataArr[3] = 32'h3333_3333;
        applyStimulus(4'b1111, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            expSrc = ((k - 1) / 4) % 4;
            checkOutput("rr_src", {30'd0, disp_src}, 32'(expSrc));
            checkOutput("rr_ack", {28'd0, ack}, ((k - 1) % 4 == 0) ? (32'd1 << expSrc) : 32'd0);
        end
        checkOutput("rr_data", disp_data, 32'h0000_0000);
        applyStimulus(4'b0000, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("rr_idle", {31'd0, busy}, 32'd0);

        // Single requester 2: capture, data change ignored until recapture
        dataArr[2] = 32'h1234_ABCD;
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        checkOutput("cap_ack",  {28'd0, ack}, 32'h4);
        checkOutput("cap_data", disp_data, 32'h1234_ABCD);
        dataArr[2] = 32'hDEAD_BEEF;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("cap_hold_data", disp_data, 32'h1234_ABCD);
            checkOutput("cap_hold_ack",  {28'd0, ack}, 32'd0);
        end
        @(negedge clk);
        checkOutput("recap_data", disp_data, 32'hDEAD_BEEF);
        checkOutput("recap_ack",  {28'd0, ack}, 32'h4);
        drainToIdle();

        // Hold freezes the dwell of requester 1 at count 1
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        checkOutput("hold_first_src", {30'd0, disp_src}, 32'd1);
        checkOutput("hold_first_ack", {28'd0, ack}, 32'h2);
        applyStimulus(4'b0011, 1'b0);
        @(negedge clk);
        applyStimulus(4'b0011, 1'b1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("hold_src",  {30'd0, disp_src}, 32'd1);
            checkOutput("hold_ack",  {28'd0, ack}, 32'd0);
            checkOutput("hold_busy", {31'd0, busy}, 32'd1);
        end
        applyStimulus(4'b0011, 1'b0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("resume_src", {30'd0, disp_src}, 32'd1);
            checkOutput("resume_ack", {28'd0, ack}, 32'd0);
        end
        @(negedge clk);
        checkOutput("resume_grant_ack", {28'd0, ack}, 32'h1);
        checkOutput("resume_grant_src", {30'd0, disp_src}, 32'd0);
        drainToIdle();

        // One-cycle request pulse: full dwell then idle with data retained
        dataArr[1] = 32'hCAFE_0001;
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("pulse_ack",  {28'd0, ack}, 32'h2);
        checkOutput("pulse_data", disp_data, 32'hCAFE_0001);
        dataArr[1] = 32'h5555_AAAA;
        repeat (3) begin
            @(negedge clk);
            checkOutput("pulse_busy", {31'd0, busy}, 32'd1);
            checkOutput("pulse_src",  {30'd0, disp_src}, 32'd1);
        end
        @(negedge clk);
        checkOutput("pulse_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("pulse_idle_data", disp_data, 32'hCAFE_0001);
        checkOutput("pulse_idle_ack",  {28'd0, ack}, 32'd0);

        // Asynchronous reset mid-dwell, then first grant from last=3
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        checkOutput("pre_reset_src", {30'd0, disp_src}, 32'd1);
        repeat (2) @(negedge clk);
        applyStimulus(4'b1010, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ack",  {28'd0, ack}, 32'd0);
        checkOutput("async_rst_data", disp_data, 32'h0);
        checkOutput("async_rst_src",  {30'd0, disp_src}, 32'd0);
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_src", {30'd0, disp_src}, 32'd1);
        checkOutput("post_rst_ack", {28'd0, ack}, 32'h2);
        drainToIdle();

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 30) rq = 4'b0000;
            else rq = 4'($urandom());
            applyStimulus(rq, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) dataArr[$urandom_range(0, 3)] = $urandom();
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        drainToIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
